// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 display driver: register addresses,
// controller state encoding and the hex digit to seven-segment encoder.
package max7219_pkg;

    // Register addresses
    localparam logic [3:0] ADDR_DIGIT0     = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1     = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2     = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3     = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4     = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5     = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6     = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7     = 4'h8;
    localparam logic [3:0] ADDR_DECODE     = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY  = 4'hA;
    localparam logic [3:0] ADDR_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN   = 4'hC;
    localparam logic [3:0] ADDR_TEST       = 4'hF;

    // Word sequence: five init words, then eight digit words per pass
    localparam int NUM_INIT_WORDS = 5;
    localparam int NUM_DIGITS     = 8;

    typedef enum logic [2:0] {
        RESET_WAIT = 3'd0,
        INIT       = 3'd1,
        CS_SETUP   = 3'd2,
        SHIFT_LOW  = 3'd3,
        SHIFT_HIGH = 3'd4,
        CS_HOLD    = 3'd5,
        GAP        = 3'd6
    } state_t;

    // Segment byte {DP, A, B, C, D, E, F, G} for a hex nibble, DP always off
    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'h7E;
            4'h1: s = 8'h30;
            4'h2: s = 8'h6D;
            4'h3: s = 8'h79;
            4'h4: s = 8'h33;
            4'h5: s = 8'h5B;
            4'h6: s = 8'h5F;
            4'h7: s = 8'h70;
            4'h8: s = 8'h7F;
            4'h9: s = 8'h7B;
            4'hA: s = 8'h77;
            4'hB: s = 8'h1F;
            4'hC: s = 8'h4E;
            4'hD: s = 8'h3D;
            4'hE: s = 8'h4F;
            default: s = 8'h47;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/max7219_shifter.sv
// Serializer for a chain of MAX7219 devices: one transaction shifts the whole
// chain word MSB-first with CLK_DIV-clock spi_clk half-periods, framed by cs.
// With MAX7219_DISPLAY_DEBUG_PINS_EN defined, the FSM state is exported.
module max7219_shifter
    import max7219_pkg::*;
#(
    parameter int NUM_CASCADES = 1,
    parameter int CLK_DIV      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [16*NUM_CASCADES-1:0]   word,
    output logic                         ready,
    output logic                         done,
    output logic                         spi_clk,
    output logic                         dout,
    output logic                         cs
`ifdef MAX7219_DISPLAY_DEBUG_PINS_EN
    ,
    output state_t                       state
`endif
);

    localparam int WW = 16 * NUM_CASCADES;
    localparam int CW = $clog2(2 * CLK_DIV) + 1;
    localparam int BW = $clog2(WW) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WW - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [WW-1:0]   shreg_q, shreg_d;
    logic            spi_clk_q, spi_clk_d;
    logic            dout_q, dout_d;
    logic            cs_q, cs_d;
    logic            done_q, done_d;

    // State, timing counters and registered serial outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RESET_WAIT;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            spi_clk_q <= 1'b0;
            dout_q    <= 1'b0;
            cs_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            spi_clk_q <= spi_clk_d;
            dout_q    <= dout_d;
            cs_q      <= cs_d;
            done_q    <= done_d;
        end
    end

    // Next state; pins are decoded from the next state so they leave flops cleanly
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        ready   = 1'b0;
        case (state_q)
            // Both hold cs high for 2*CLK_DIV clocks before the next word may start
            RESET_WAIT, GAP: begin
                if (cnt_q == GAP_LAST) begin
                    ready = 1'b1;
                    cnt_d = '0;
                    if (start) begin
                        state_d = CS_SETUP;
                        shreg_d = word;
                        bit_d   = '0;
                    end else begin
                        state_d = INIT;
                    end
                end
            end
            INIT: begin
                ready = 1'b1;
                cnt_d = '0;
                if (start) begin
                    state_d = CS_SETUP;
                    shreg_d = word;
                    bit_d   = '0;
                end
            end
            CS_SETUP: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = SHIFT_LOW;
                end
            end
            SHIFT_LOW: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = SHIFT_HIGH;
                end
            end
            SHIFT_HIGH: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = CS_HOLD;
                    end else begin
                        state_d = SHIFT_LOW;
                        shreg_d = {shreg_q[WW-2:0], 1'b0};
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            CS_HOLD: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = GAP;
                    done_d  = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = RESET_WAIT;
            end
        endcase

        spi_clk_d = (state_d == SHIFT_HIGH);
        cs_d      = !(state_d == CS_SETUP || state_d == SHIFT_LOW ||
                      state_d == SHIFT_HIGH || state_d == CS_HOLD);
        dout_d    = (state_d == CS_SETUP || state_d == SHIFT_LOW ||
                     state_d == SHIFT_HIGH) ? shreg_d[WW-1] : 1'b0;
    end

    assign spi_clk = spi_clk_q;
    assign dout    = dout_q;
    assign cs      = cs_q;
    assign done    = done_q;
`ifdef MAX7219_DISPLAY_DEBUG_PINS_EN
    assign state   = state_q;
`endif

endmodule

// File: rtl/max7219_display.sv
// MAX7219 chain driver: sends the init sequence after reset, then refreshes
// digits 1..8 endlessly from a per-pass snapshot of frame as hex digits.
// Optional debug outputs on pin are enabled by MAX7219_DISPLAY_DEBUG_PINS_EN.
module max7219_display
    import max7219_pkg::*;
#(
    parameter int NUM_CASCADES = 1,
    parameter int INTENSITY    = 8,
    parameter int CLK_DIV      = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   frame [4*NUM_CASCADES],
    output logic         spi_clk,
    output logic         dout,
    output logic         cs,
    output logic         stop,
    output logic [10:1]  pin
);

    localparam logic [3:0] INT_NIB   = 4'(INTENSITY);
    localparam logic [3:0] IDX_DIG1  = 4'(NUM_INIT_WORDS);
    localparam logic [3:0] IDX_DIG8  = 4'(NUM_INIT_WORDS + NUM_DIGITS - 1);

    // idx: 0..4 init words, 5..12 digit addresses 1..8
    logic [3:0]                  idx_q, idx_d;
    logic [7:0]                  snap_q [4*NUM_CASCADES];
    logic [7:0]                  snap_d [4*NUM_CASCADES];
    logic [16*NUM_CASCADES-1:0]  word_w;
    logic                        ready, done;
`ifdef MAX7219_DISPLAY_DEBUG_PINS_EN
    state_t                      dbg_state;
`endif

    // Word index and frame snapshot registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            snap_q <= '{default: '0};
        end else begin
            idx_q  <= idx_d;
            snap_q <= snap_d;
        end
    end

    // Advance after each transaction; snapshot frame just before digit 1 is built
    always_comb begin
        idx_d  = idx_q;
        snap_d = snap_q;
        if (done) begin
            if (idx_q == IDX_DIG1 - 4'd1 || idx_q == IDX_DIG8) begin
                idx_d  = IDX_DIG1;
                snap_d = frame;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end
    end

    // One 16-bit word per chip; chip NUM_CASCADES-1 sits in the top bits so it shifts first
    for (genvar gi = 0; gi < NUM_CASCADES; gi++) begin : g_chip
        logic [2:0]  nib_sel;
        logic [7:0]  sel_byte;
        logic [3:0]  nib;
        logic [11:0] addr_data;

        // digit d shows nibble 8-d, and d = idx-4
        assign nib_sel = 3'(4'd12 - idx_q);
        assign nib     = nib_sel[0] ? sel_byte[3:0] : sel_byte[7:4];

        // Pick this chip's byte holding the selected nibble
        always_comb begin
            case (nib_sel[2:1])
                2'd0:    sel_byte = snap_q[4*gi];
                2'd1:    sel_byte = snap_q[4*gi+1];
                2'd2:    sel_byte = snap_q[4*gi+2];
                default: sel_byte = snap_q[4*gi+3];
            endcase
        end

        // Register address and data for the current word index
        always_comb begin
            case (idx_q)
                4'd0:    addr_data = {ADDR_SHUTDOWN, 8'h01};
                4'd1:    addr_data = {ADDR_TEST, 8'h00};
                4'd2:    addr_data = {ADDR_DECODE, 8'h00};
                4'd3:    addr_data = {ADDR_SCAN_LIMIT, 8'h07};
                4'd4:    addr_data = {ADDR_INTENSITY, 4'h0, INT_NIB};
                default: addr_data = {idx_q - 4'd4, hex_to_seg(nib)};
            endcase
        end

        assign word_w[16*gi +: 16] = {4'h0, addr_data};
    end

    max7219_shifter #(
        .NUM_CASCADES (NUM_CASCADES),
        .CLK_DIV      (CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .start   (ready),
        .word    (word_w),
        .ready   (ready),
        .done    (done),
        .spi_clk (spi_clk),
        .dout    (dout),
        .cs      (cs)
`ifdef MAX7219_DISPLAY_DEBUG_PINS_EN
        ,
        .state   (dbg_state)
`endif
    );

    // done coincides with cs rising, so this marks the end of the digit-8 word
    assign stop = done & (idx_q == IDX_DIG8);

`ifdef MAX7219_DISPLAY_DEBUG_PINS_EN
    logic [2:0] dbg_digit;
    assign dbg_digit = (idx_q >= IDX_DIG1) ? 3'(idx_q - IDX_DIG1) : 3'd0;
    assign pin = reset ? 10'd0 : {dbg_digit, dbg_state, stop, cs, dout, spi_clk};
`else
    assign pin = '0;
`endif

endmodule

// File: tb/tb_max7219_display.sv
// Self-checking bench: a bus monitor decodes each cs-framed word and checks
// serial timing; tasks compare decoded words against a frame-based model.
module tb_max7219_display;

    localparam int NC  = 2;
    localparam int CD  = 2;
    localparam int INT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  frame [4*NC];
    logic        spi_clk, dout, cs, stop;
    logic [10:1] pin;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    max7219_display #(
        .NUM_CASCADES (NC),
        .INTENSITY    (INT),
        .CLK_DIV      (CD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .frame   (frame),
        .spi_clk (spi_clk),
        .dout    (dout),
        .cs      (cs),
        .stop    (stop),
        .pin     (pin)
    );

    logic [7:0] seg_tab [16] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70,
                                 8'h7F, 8'h7B, 8'h77, 8'h1F, 8'h4E, 8'h3D, 8'h4F, 8'h47};
    logic [7:0] pass_frame [4*NC];

    // ---------------- bus monitor ----------------
    longint      cyc = 0;
    longint      last_rise = 0;
    longint      last_cs_rise = -1;
    logic [31:0] word_q [$];
    int          stop_count = 0, timing_bad = 0, gap_bad = 0, stop_bad = 0, malformed = 0;
    logic        prev_cs = 1'b1, prev_spi = 1'b0, prev_dout = 1'b0, prev_stop = 1'b0;
    bit          collecting = 0, have_rise = 0;
    int          nbits = 0;
    logic [31:0] sh = '0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            collecting   = 0;
            have_rise    = 0;
            last_cs_rise = -1;
        end else begin
            if (prev_cs && !cs) begin
                collecting = 1;
                nbits      = 0;
                sh         = '0;
                have_rise  = 0;
                if (last_cs_rise >= 0 && (cyc - last_cs_rise) < 2*CD) gap_bad++;
            end
            if (!cs && collecting && !prev_spi && spi_clk) begin
                sh = {sh[30:0], dout};
                nbits++;
                if (have_rise && (cyc - last_rise) != 2*CD) timing_bad++;
                last_rise = cyc;
                have_rise = 1;
            end
            if (spi_clk && prev_spi && dout !== prev_dout) timing_bad++;
            if (cs && spi_clk) timing_bad++;
            if (!prev_cs && cs && collecting) begin
                if (nbits == 32) word_q.push_back(sh);
                else malformed++;
                collecting   = 0;
                last_cs_rise = cyc;
            end
            if (stop) begin
                stop_count++;
                if (prev_stop || !(!prev_cs && cs)) stop_bad++;
            end
        end
        prev_cs   = cs;
        prev_spi  = spi_clk;
        prev_dout = dout;
        prev_stop = stop;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] init_word(input int i);
        logic [15:0] w;
        logic [31:0] r;
        case (i)
            0: w = 16'h0C01;
            1: w = 16'h0F00;
            2: w = 16'h0900;
            3: w = 16'h0B07;
            default: w = {8'h0A, 4'h0, 4'(INT)};
        endcase
        r = '0;
        for (int c = 0; c < NC; c++) r = (r << 16) | {16'h0, w};
        return r;
    endfunction

    function automatic logic [31:0] model_word(input int d, input logic [7:0] f [4*NC]);
        logic [31:0] r;
        logic [7:0]  b;
        logic [3:0]  nib;
        int          n;
        r = '0;
        n = 8 - d;
        for (int c = NC - 1; c >= 0; c--) begin
            b   = f[4*c + n/2];
            nib = (n % 2 == 0) ? b[7:4] : b[3:0];
            r   = (r << 16) | {16'h0, 4'h0, 4'(d), seg_tab[nib]};
        end
        return r;
    endfunction

    task automatic randomize_frame();
        for (int i = 0; i < 4*NC; i++) frame[i] = 8'($urandom);
    endtask

    task automatic get_word(output logic [31:0] w, output bit ok);
        int n;
        n  = 0;
        ok = 0;
        w  = 'x;
        while (word_q.size() == 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (word_q.size() != 0) begin
            w  = word_q.pop_front();
            ok = 1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n;
        logic [7:0] fixed [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        for (int i = 0; i < 4*NC; i++) frame[i] = fixed[i];
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (spi_clk !== 1'b0) begin failures++; $display("FAIL reset_spi_clk: got %b expected 0", spi_clk); end
        checks++; if (dout !== 1'b0)    begin failures++; $display("FAIL reset_dout: got %b expected 0", dout); end
        checks++; if (cs !== 1'b1)      begin failures++; $display("FAIL reset_cs: got %b expected 1", cs); end
        checks++; if (stop !== 1'b0)    begin failures++; $display("FAIL reset_stop: got %b expected 0", stop); end
        checks++; if (pin !== 10'd0)    begin failures++; $display("FAIL reset_pin: got %h expected 000", pin); end
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (cs === 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 2*CD) begin failures++; $display("FAIL first_cs_latency: got %0d clocks expected %0d", n, 2*CD); end
        else $display("reset released, first cs fall after %0d clocks", n);
    endtask

    task automatic test_init();
        logic [31:0] w;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            get_word(w, ok);
            checks++;
            if (!ok || w !== init_word(i)) begin
                failures++;
                $display("FAIL init_word%0d: got %h expected %h timeout=%0d", i, w, init_word(i), !ok);
            end else $display("init word %0d = %h", i, w);
        end
        pass_frame = frame;
    endtask

    task automatic test_refresh(input int change_at);
        logic [31:0] w, exp_w;
        bit ok;
        int s0;
        s0 = stop_count;
        for (int d = 1; d <= 8; d++) begin
            get_word(w, ok);
            exp_w = model_word(d, pass_frame);
            checks++;
            if (!ok || w !== exp_w) begin
                failures++;
                $display("FAIL digit%0d_word: got %h expected %h timeout=%0d", d, w, exp_w, !ok);
            end else $display("digit %0d word = %h", d, w);
            if (d == 8) begin
                pass_frame = frame;
                checks++;
                if (stop_count - s0 != 1) begin
                    failures++;
                    $display("FAIL stop_per_pass: got %0d pulses expected 1", stop_count - s0);
                end
            end
            if (d == change_at) begin
                repeat (20) @(posedge clk);
                randomize_frame();
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w, exp_w;
        bit ok;
        for (int d = 1; d <= 3; d++) begin
            get_word(w, ok);
            exp_w = model_word(d, pass_frame);
            checks++;
            if (!ok || w !== exp_w) begin
                failures++;
                $display("FAIL pre_abort_digit%0d: got %h expected %h timeout=%0d", d, w, exp_w, !ok);
            end else $display("digit %0d word = %h", d, w);
        end
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (cs !== 1'b0) begin failures++; $display("FAIL mid_shift_cs: got %b expected 0", cs); end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (cs !== 1'b1)      begin failures++; $display("FAIL abort_cs: got %b expected 1", cs); end
        checks++; if (spi_clk !== 1'b0) begin failures++; $display("FAIL abort_spi_clk: got %b expected 0", spi_clk); end
        $display("reset asserted during digit 4 shift");
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        word_q.delete();
        test_init();
        test_refresh(0);
    endtask

    task automatic test_timing();
        checks++; if (timing_bad != 0) begin failures++; $display("FAIL bit_timing: got %0d violations expected 0", timing_bad); end
        checks++; if (gap_bad != 0)    begin failures++; $display("FAIL cs_gap: got %0d violations expected 0", gap_bad); end
        checks++; if (stop_bad != 0)   begin failures++; $display("FAIL stop_shape: got %0d violations expected 0", stop_bad); end
        checks++; if (malformed != 0)  begin failures++; $display("FAIL word_length: got %0d bad words expected 0", malformed); end
`ifdef MAX7219_DISPLAY_DEBUG_PINS_EN
        #1;
        checks++; if (pin[3] !== cs) begin failures++; $display("FAIL pin_cs: got %b expected %b", pin[3], cs); end
`else
        #1;
        checks++; if (pin !== 10'd0) begin failures++; $display("FAIL pin_idle: got %h expected 000", pin); end
`endif
        $display("timing summary: timing=%0d gap=%0d stop=%0d len=%0d", timing_bad, gap_bad, stop_bad, malformed);
    endtask

    initial begin
        test_reset();
        test_init();
        test_refresh(0);                        // fixed frame pass
        test_refresh(0);                        // fixed frame repeated
        test_refresh($urandom_range(1, 7));     // change mid-pass, current pass keeps old data
        test_refresh(8);                        // change right after digit 8
        test_refresh($urandom_range(1, 8));
        test_refresh(0);
        test_reset_mid();
        test_timing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
